// File: rtl/imem_loader.sv
// Boot-time program loader: assembles big-endian 24-bit words from a byte stream,
// writes them to instruction memory and holds the CPU in reset until the image is loaded.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [23:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CHK, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_FIN, S_DONE, S_ERR
  } state_t;
`endif

  state_t             state_q;
  logic [7:0]         len_hi_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   idx_q;
  logic [23:0]        word_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         xor_q;
`endif

  logic               byte_ready_q;
  logic               imem_we_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic [23:0]        imem_wdata_q;
  logic               cpu_rst_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  logic               accept;
  logic [15:0]        hdr16;
  logic [CNT_W-1:0]   len_d;
  logic [CNT_W-1:0]   idx_d;
  logic [23:0]        word_d;
  logic               last_word;

  always_comb begin
    accept    = byte_valid && byte_ready_q;
    hdr16     = {len_hi_q, byte_in};
    len_d     = hdr16[CNT_W-1:0];
    idx_d     = idx_q + 1'b1;
    word_d    = {word_q[15:0], byte_in};
    last_word = (idx_d == len_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // NOTE: the write strobe defaults low every cycle so a B2 accept yields a single-cycle pulse.
      imem_we_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LEN_HI;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_rst_q    <= 1'b1;
            idx_q        <= '0;
            word_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_hi_q <= byte_in;
            state_q  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_q <= len_d;
            if (len_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q      <= S_CHK;
`else
              state_q      <= S_DONE;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              cpu_rst_q    <= 1'b0;
`endif
            end else if (len_d > DEPTH) begin
              state_q      <= S_ERR;
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              error_q      <= 1'b1;
            end else begin
              state_q <= S_B0;
            end
          end
        end

        S_B0, S_B1: begin
          if (accept) begin
            word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_q ^ byte_in;
`endif
            state_q <= (state_q == S_B0) ? S_B1 : S_B2;
          end
        end

        S_B2: begin
          if (accept) begin
            word_q       <= word_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= xor_q ^ byte_in;
`endif
            imem_we_q    <= 1'b1;
            imem_addr_q  <= idx_q[ADDR_W-1:0];
            imem_wdata_q <= word_d;
            idx_q        <= idx_d;
            if (!last_word) begin
              state_q <= S_B0;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              state_q      <= S_CHK;
`else
              // The write cycle of the final word precedes DONE, so no more bytes are taken.
              state_q      <= S_FIN;
              byte_ready_q <= 1'b0;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            if (byte_in == xor_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
`else
        S_FIN: begin
          state_q   <= S_DONE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          cpu_rst_q <= 1'b0;
        end
`endif

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-count based load model checks two
// instances (ADDR_W=10 and ADDR_W=4) every cycle, plus literal expectations per scenario.
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic        byte_ready0, imem_we0, cpu_rst0, busy0, done0, error0;
  logic [9:0]  imem_addr0;
  logic [23:0] imem_wdata0;
  logic        byte_ready4, imem_we4, cpu_rst4, busy4, done4, error4;
  logic [3:0]  imem_addr4;
  logic [23:0] imem_wdata4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wdata(imem_wdata0), .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .error(error0)
  );

  imem_loader #(.ADDR_W(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready4), .imem_we(imem_we4), .imem_addr(imem_addr4),
    .imem_wdata(imem_wdata4), .cpu_rst(cpu_rst4), .busy(busy4), .done(done4), .error(error4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Load model: tracks how many bytes of the current image were taken and what they mean.
  typedef struct {
    bit          ready, we, busy, done, err, cpu_rst, active, pend;
    int          addr;
    logic [23:0] wdata, word;
    int          acc, n;
    logic [7:0]  nhi, xr;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r = '{default: 0};
    r.cpu_rst = 1'b1;
    return r;
  endfunction

  function automatic model_t finish(model_t s, bit ok);
    s.active = 1'b0;
    s.ready  = 1'b0;
    s.busy   = 1'b0;
    s.pend   = 1'b0;
    if (ok) begin
      s.done    = 1'b1;
      s.cpu_rst = 1'b0;
    end else begin
      s.err = 1'b1;
    end
    return s;
  endfunction

  function automatic model_t step(model_t s, int depth, logic st, logic v, logic [7:0] b);
    model_t r;
    int p;
    r = s;
    r.we = 1'b0;
    p = s.acc - 2;
    if (s.pend) begin
      r = finish(r, 1'b1);
    end else if (!s.active) begin
      if (st) begin
        r.active = 1'b1; r.acc = 0; r.busy = 1'b1; r.done = 1'b0; r.err = 1'b0;
        r.cpu_rst = 1'b1; r.ready = 1'b1; r.xr = 8'h00; r.word = 24'h0;
      end
    end else if (s.ready && v) begin
      r.acc = s.acc + 1;
      if (s.acc == 0) begin
        r.nhi = b;
      end else if (s.acc == 1) begin
        r.n = int'(s.nhi) * 256 + int'(b);
        if (r.n == 0) begin
          if (!CHK_EN) r = finish(r, 1'b1);
        end else if (r.n > depth) begin
          r = finish(r, 1'b0);
        end
      end else if (p < 3 * s.n) begin
        r.word[23 - 8 * (p % 3) -: 8] = b;
        r.xr = s.xr ^ b;
        if (p % 3 == 2) begin
          r.we = 1'b1;
          r.addr = p / 3;
          r.wdata = r.word;
          if (p / 3 == s.n - 1 && !CHK_EN) begin
            r.ready = 1'b0;
            r.pend  = 1'b1;
          end
        end
      end else begin
        r = finish(r, b == s.xr);
      end
    end
    return r;
  endfunction

  model_t m0, m4;

  always @(posedge clk or posedge rst) begin
    if (rst) m0 <= model_reset();
    else     m0 <= step(m0, 1024, start, byte_valid, byte_in);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m4 <= model_reset();
    else     m4 <= step(m4, 16, start, byte_valid, byte_in);
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t wlog[$];
  int  we4_cnt = 0;
  int  done_cyc = -1;
  bit  done_prev = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("d0.byte_ready", byte_ready0, m0.ready);
      check("d0.imem_we",    imem_we0,    m0.we);
      check("d0.imem_addr",  imem_addr0,  m0.addr);
      check("d0.imem_wdata", imem_wdata0, m0.wdata);
      check("d0.cpu_rst",    cpu_rst0,    m0.cpu_rst);
      check("d0.busy",       busy0,       m0.busy);
      check("d0.done",       done0,       m0.done);
      check("d0.error",      error0,      m0.err);
      check("d4.byte_ready", byte_ready4, m4.ready);
      check("d4.imem_we",    imem_we4,    m4.we);
      check("d4.imem_addr",  imem_addr4,  m4.addr);
      check("d4.imem_wdata", imem_wdata4, m4.wdata);
      check("d4.cpu_rst",    cpu_rst4,    m4.cpu_rst);
      check("d4.busy",       busy4,       m4.busy);
      check("d4.done",       done4,       m4.done);
      check("d4.error",      error4,      m4.err);
      if (imem_we0) wlog.push_back('{int'(imem_addr0), int'(imem_wdata0), cyc});
      if (imem_we4) we4_cnt = we4_cnt + 1;
      if (done0 && !done_prev) done_cyc = cyc;
      done_prev = done0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    bit take;
    take = 1'b0;
    if (stall) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_in = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      take = m0.ready;
      tick();
      if (take) break;
    end
    check("send_accepted", take, 1'b1);
  endtask

  task automatic load(input logic [7:0] img[$], input bit stall);
    pulse_start();
    foreach (img[i]) send(img[i], stall);
    idle(4);
  endtask

  task automatic pulse_rst();
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] img[$];
    logic [7:0] x;
    int base4;

    // Reset then idle
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(20);
    check("idle_cpu_rst", cpu_rst0, 1'b1);
    check("idle_ready", byte_ready0, 1'b0);
    check("idle_done", done0, 1'b0);
    check("idle_error", error0, 1'b0);
    check("idle_we_count", wlog.size(), 0);

    // Basic two-word load
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    if (CHK_EN) img.push_back(8'hF9);
    wlog.delete();
    load(img, 1'b0);
    check("basic_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("basic_addr0", wlog[0].addr, 0);
      check("basic_data0", wlog[0].data, 32'h123456);
      check("basic_addr1", wlog[1].addr, 1);
      check("basic_data1", wlog[1].data, 32'hABCDEF);
      check("basic_done_lat", done_cyc - wlog[1].cyc, 1);
    end
    check("basic_done", done0, 1'b1);
    check("basic_cpu_rst", cpu_rst0, 1'b0);

    // Same image with byte_valid gaps
    wlog.delete();
    load(img, 1'b1);
    check("stall_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("stall_data0", wlog[0].data, 32'h123456);
      check("stall_addr1", wlog[1].addr, 1);
      check("stall_data1", wlog[1].data, 32'hABCDEF);
    end
    check("stall_done", done0, 1'b1);

    // Exactly 2**4 words: fills the small memory completely
    img = '{8'h00, 8'h10};
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img.push_back(8'(i));
      img.push_back(8'(i) ^ 8'hF0);
      img.push_back(8'h3C);
      x = x ^ 8'(i) ^ (8'(i) ^ 8'hF0) ^ 8'h3C;
    end
    if (CHK_EN) img.push_back(x);
    base4 = we4_cnt;
    load(img, 1'b0);
    check("full4_nwr", we4_cnt - base4, 16);
    check("full4_done", done4, 1'b1);
    check("full4_last_addr", imem_addr4, 4'hF);
    check("full4_last_data", imem_wdata4, 32'h0FFF3C);

    // Oversize header on the small instance
    base4 = we4_cnt;
    img = '{8'h00, 8'h11};
    load(img, 1'b0);
    check("over4_error", error4, 1'b1);
    check("over4_cpu_rst", cpu_rst4, 1'b1);
    check("over4_busy", busy4, 1'b0);
    check("over4_nwr", we4_cnt - base4, 0);
    check("over0_busy", busy0, 1'b1);
    pulse_rst();
    idle(2);

    // Reset mid-load after four bytes
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", byte_ready0, 1'b0);
    check("midrst_we", imem_we0, 1'b0);
    check("midrst_addr", imem_addr0, 0);
    check("midrst_wdata", imem_wdata0, 0);
    check("midrst_cpu_rst", cpu_rst0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_done", done0, 1'b0);
    check("midrst_error", error0, 1'b0);
    tick();
    rst = 1'b0;
    idle(2);
    img = '{8'h00, 8'h01, 8'hA5, 8'h5A, 8'hC3};
    if (CHK_EN) img.push_back(8'h3C);
    wlog.delete();
    load(img, 1'b0);
    check("reload_nwr", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("reload_addr0", wlog[0].addr, 0);
      check("reload_data0", wlog[0].data, 32'hA55AC3);
    end
    check("reload_done", done0, 1'b1);

    if (CHK_EN) begin
      img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
      load(img, 1'b0);
      check("chk_ok_done", done0, 1'b1);
      check("chk_ok_cpu_rst", cpu_rst0, 1'b0);
      img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
      load(img, 1'b0);
      check("chk_bad_error", error0, 1'b1);
      check("chk_bad_done", done0, 1'b0);
      check("chk_bad_cpu_rst", cpu_rst0, 1'b1);
      img = '{8'h00, 8'h00, 8'h00};
      load(img, 1'b0);
      check("chk_empty_done", done0, 1'b1);
    end else begin
      img = '{8'h00, 8'h00};
      load(img, 1'b0);
      check("empty_done", done0, 1'b1);
      check("empty_cpu_rst", cpu_rst0, 1'b0);
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
